vx_dispatch_lane_sequencer: RTL and testbench



---
 rtl/vx_dispatch_lane_sequencer.sv | 170 +++++++++++++++++
 tb/tb_vx_dispatch_lane_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dispatch_lane_sequencer.sv
// Splits one held full-warp dispatch packet into NUM_LANES-wide batches for a narrow execute unit.
// Optional feature: define VX_DISPATCH_SKIP_EMPTY_EN to skip batches whose tmask slice is all-zero.
module vx_dispatch_lane_sequencer #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int UUID_W      = 8,
    parameter int WIS_W       = 2,
    parameter int OP_TYPE_W   = 4,
    parameter int OP_MOD_W    = 3,
    parameter int PC_W        = 32,
    parameter int NR_W        = 5,
    localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
    localparam int PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1,
    localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int HDR_W       = UUID_W + WIS_W + OP_TYPE_W + OP_MOD_W + 3 + PC_W + XLEN + NR_W + TID_W + 1,
    localparam int RS_W        = NUM_THREADS * XLEN,
    localparam int LANE_RS_W   = NUM_LANES * XLEN,
    localparam int DATA_W      = HDR_W + NUM_THREADS + 3 * RS_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [HDR_W-1:0]      out_header,
    output logic [NUM_LANES-1:0]  out_tmask,
    output logic [LANE_RS_W-1:0]  out_rs1_data,
    output logic [LANE_RS_W-1:0]  out_rs2_data,
    output logic [LANE_RS_W-1:0]  out_rs3_data,
    output logic [PID_W-1:0]      out_pid,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  out_ready
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;

`ifdef VX_DISPATCH_SKIP_EMPTY_EN
    localparam bit SKIP_EMPTY = 1'b1;
`else
    localparam bit SKIP_EMPTY = 1'b0;
`endif

    // Packet layout, MSB first: uuid, wis, tmask, op_type..is_mstore, rs1, rs2, rs3.
    localparam int HI_HDR_W   = UUID_W + WIS_W;
    localparam int LO_HDR_W   = HDR_W - HI_HDR_W;
    localparam int RS3_LSB    = 0;
    localparam int RS2_LSB    = RS_W;
    localparam int RS1_LSB    = 2 * RS_W;
    localparam int LO_HDR_LSB = 3 * RS_W;
    localparam int TMASK_LSB  = LO_HDR_LSB + LO_HDR_W;
    localparam int HI_HDR_LSB = TMASK_LSB + NUM_THREADS;

    // Lowest emitted batch index at or after 'from'; zero when there is none.
    function automatic logic [PID_W-1:0] first_live(input logic [NUM_THREADS-1:0] tmask, input int from);
        logic [PID_W-1:0] idx;
        idx = {PID_W{1'b0}};
        for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
            if ((p >= from) && (!SKIP_EMPTY || (|tmask[p*NUM_LANES +: NUM_LANES]))) begin
                idx = PID_W'(p);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when some batch at or after 'from' is still to be emitted.
    function automatic logic any_live(input logic [NUM_THREADS-1:0] tmask, input int from);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NUM_PACKETS; p++) begin
            hit = hit | ((p >= from) && (!SKIP_EMPTY || (|tmask[p*NUM_LANES +: NUM_LANES])));
        end
        return hit;
    endfunction

    logic [0:0]              state_q, state_d;
    logic [PID_W-1:0]        pid_q, pid_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [NUM_THREADS-1:0]  tmask_q_s;
    logic [NUM_THREADS-1:0]  in_tmask_s;
    logic [PID_W-1:0]        in_first_s;
    logic [PID_W-1:0]        held_first_s;
    logic [PID_W-1:0]        held_next_s;
    logic                    busy_s;
    logic                    eop_s;

    assign tmask_q_s    = data_q[TMASK_LSB +: NUM_THREADS];
    assign in_tmask_s   = in_data[TMASK_LSB +: NUM_THREADS];
    assign in_first_s   = first_live(in_tmask_s, 0);
    assign held_first_s = first_live(tmask_q_s, 0);
    assign held_next_s  = first_live(tmask_q_s, int'(pid_q) + 1);
    assign busy_s       = (state_q == STATE_BUSY);
    assign eop_s        = ~any_live(tmask_q_s, int'(pid_q) + 1);

    assign in_ready   = ~busy_s | (out_ready & eop_s);
    assign out_valid  = busy_s;
    assign out_pid    = pid_q;
    assign out_sop    = busy_s & (pid_q == held_first_s);
    assign out_eop    = busy_s & eop_s;
    assign out_header = {data_q[HI_HDR_LSB +: HI_HDR_W], data_q[LO_HDR_LSB +: LO_HDR_W]};

    // Select the lane slice of the held packet addressed by pid_q.
    always_comb begin
        out_tmask    = {NUM_LANES{1'b0}};
        out_rs1_data = {LANE_RS_W{1'b0}};
        out_rs2_data = {LANE_RS_W{1'b0}};
        out_rs3_data = {LANE_RS_W{1'b0}};
        for (int p = 0; p < NUM_PACKETS; p++) begin
            out_tmask    = out_tmask    | ({NUM_LANES{pid_q == PID_W'(p)}} & tmask_q_s[p*NUM_LANES +: NUM_LANES]);
            out_rs1_data = out_rs1_data | ({LANE_RS_W{pid_q == PID_W'(p)}} & data_q[RS1_LSB + p*LANE_RS_W +: LANE_RS_W]);
            out_rs2_data = out_rs2_data | ({LANE_RS_W{pid_q == PID_W'(p)}} & data_q[RS2_LSB + p*LANE_RS_W +: LANE_RS_W]);
            out_rs3_data = out_rs3_data | ({LANE_RS_W{pid_q == PID_W'(p)}} & data_q[RS3_LSB + p*LANE_RS_W +: LANE_RS_W]);
        end
    end

    // Next-state: load on accept, advance pid on batch accept, retire after the last batch.
    always_comb begin
        state_d = state_q;
        pid_d   = pid_q;
        data_d  = data_q;
        case (state_q)
            STATE_IDLE: begin
                if (in_valid) begin
                    state_d = STATE_BUSY;
                    data_d  = in_data;
                    pid_d   = in_first_s;
                end else begin
                    state_d = STATE_IDLE;
                end
            end
            STATE_BUSY: begin
                if (out_ready) begin
                    if (!eop_s) begin
                        pid_d = held_next_s;
                    end else if (in_valid) begin
                        // Back-to-back load on the retiring cycle keeps the lane busy without a bubble.
                        data_d = in_data;
                        pid_d  = in_first_s;
                    end else begin
                        state_d = STATE_IDLE;
                    end
                end else begin
                    state_d = STATE_BUSY;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // State, batch index and held packet registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STATE_IDLE;
            pid_q   <= {PID_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_vx_dispatch_lane_sequencer.sv
// Randomized bench for vx_dispatch_lane_sequencer against a batch-list reference model.
// Honors VX_DISPATCH_SKIP_EMPTY_EN the same way as the design.
module tb_vx_dispatch_lane_sequencer;

    localparam int NT     = 4;
    localparam int NL     = 2;
    localparam int XLEN   = 32;
    localparam int NP     = NT / NL;
    localparam int PID_W  = 1;
    localparam int HDR_W  = 8 + 2 + 4 + 3 + 3 + 32 + 32 + 5 + 2 + 1;
    localparam int HI_W   = 10;
    localparam int LO_W   = HDR_W - HI_W;
    localparam int RS_W   = NT * XLEN;
    localparam int LRS_W  = NL * XLEN;
    localparam int DATA_W = HDR_W + NT + 3 * RS_W;

`ifdef VX_DISPATCH_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [PID_W-1:0] pid;
        logic             sop;
        logic             eop;
        logic [NL-1:0]    tm;
        logic [HDR_W-1:0] hdr;
        logic [LRS_W-1:0] r1;
        logic [LRS_W-1:0] r2;
        logic [LRS_W-1:0] r3;
    } batch_t;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [HDR_W-1:0]  out_header;
    logic [NL-1:0]     out_tmask;
    logic [LRS_W-1:0]  out_rs1_data;
    logic [LRS_W-1:0]  out_rs2_data;
    logic [LRS_W-1:0]  out_rs3_data;
    logic [PID_W-1:0]  out_pid;
    logic              out_sop;
    logic              out_eop;
    logic              out_ready;

    int n_checks;
    int n_fail;

    batch_t exp_q[$];

    logic [NT-1:0]     pk_tm;
    logic [HDR_W-1:0]  pk_hdr;
    logic [RS_W-1:0]   pk_r1;
    logic [RS_W-1:0]   pk_r2;
    logic [RS_W-1:0]   pk_r3;
    logic [DATA_W-1:0] pk_data;

    vx_dispatch_lane_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_header   (out_header),
        .out_tmask    (out_tmask),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rs3_data (out_rs3_data),
        .out_pid      (out_pid),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_data();
        pk_data = {pk_hdr[HDR_W-1 -: HI_W], pk_tm, pk_hdr[LO_W-1:0], pk_r1, pk_r2, pk_r3};
    endtask

    task automatic make_pkt(input logic [NT-1:0] tm);
        pk_tm = tm;
        for (int i = 0; i < HDR_W; i++) pk_hdr[i] = 1'($urandom);
        for (int i = 0; i < NT; i++) begin
            pk_r1[i*XLEN +: XLEN] = $urandom;
            pk_r2[i*XLEN +: XLEN] = $urandom;
            pk_r3[i*XLEN +: XLEN] = $urandom;
        end
        build_data();
    endtask

    // The batches a packet must produce, in order, from the tmask rules alone.
    task automatic push_packet();
        int pids[$];
        batch_t b;
        for (int p = 0; p < NP; p++) begin
            if (!SKIP || (pk_tm[p*NL +: NL] != '0)) pids.push_back(p);
        end
        if (pids.size() == 0) pids.push_back(0);
        for (int i = 0; i < pids.size(); i++) begin
            b.pid = PID_W'(pids[i]);
            b.sop = (i == 0);
            b.eop = (i == pids.size() - 1);
            b.tm  = pk_tm[pids[i]*NL +: NL];
            b.hdr = pk_hdr;
            b.r1  = pk_r1[pids[i]*LRS_W +: LRS_W];
            b.r2  = pk_r2[pids[i]*LRS_W +: LRS_W];
            b.r3  = pk_r3[pids[i]*LRS_W +: LRS_W];
            exp_q.push_back(b);
        end
    endtask

    // One clock: drive, check mid-cycle, update model, return at posedge+1.
    task automatic run_cycle(input logic v, input logic rdy);
        logic exp_valid;
        logic exp_inr;
        in_valid  = v;
        in_data   = pk_data;
        out_ready = rdy;
        @(negedge clk);
        exp_valid = (exp_q.size() != 0);
        exp_inr   = !exp_valid || (rdy && exp_q[0].eop);
        check_eq("out_valid", out_valid, exp_valid);
        check_eq("in_ready", in_ready, exp_inr);
        if (exp_valid) begin
            check_eq("pid", out_pid, exp_q[0].pid);
            check_eq("sop", out_sop, exp_q[0].sop);
            check_eq("eop", out_eop, exp_q[0].eop);
            check_eq("tmask", out_tmask, exp_q[0].tm);
            check_eq("header", out_header, exp_q[0].hdr);
            check_eq("rs1", out_rs1_data, exp_q[0].r1);
            check_eq("rs2", out_rs2_data, exp_q[0].r2);
            check_eq("rs3", out_rs3_data, exp_q[0].r3);
            if (rdy) void'(exp_q.pop_front());
        end
        if (v && exp_inr) push_packet();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        pk_tm     = '0;
        pk_hdr    = '0;
        pk_r1     = '0;
        pk_r2     = '0;
        pk_r3     = '0;
        pk_data   = '0;
        #12;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_pid", out_pid, 1'b0);
        check_eq("rst_sop", out_sop, 1'b0);
        check_eq("rst_eop", out_eop, 1'b0);
        check_eq("rst_header", out_header, '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, 1'($urandom));
            check_eq("idle_pid", out_pid, 1'b0);
        end

        // Known-value packet: rs1 lanes {4,3,2,1}.
        make_pkt(4'b1111);
        pk_r1 = {32'd4, 32'd3, 32'd2, 32'd1};
        build_data();
        run_cycle(1'b1, 1'b1);
        check_eq("first_rs1", out_rs1_data, {32'd2, 32'd1});
        check_eq("first_sop", out_sop, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);

        // Back-to-back packets with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            make_pkt(4'b1111);
            run_cycle(i < 3, 1'b1);
        end

        // Stall on pid1 for three cycles while a new packet is offered.
        make_pkt(4'b1111);
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b0, 1'b1);
        make_pkt(4'b0101);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
        run_cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);

        // Upper half only, then an all-zero mask.
        make_pkt(4'b1100);
        run_cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);
        make_pkt(4'b0000);
        run_cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);

        // Reset while pid0 is held.
        make_pkt(4'b1111);
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("midrst_valid", out_valid, 1'b0);
        check_eq("midrst_in_ready", in_ready, 1'b1);
        check_eq("midrst_pid", out_pid, 1'b0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        make_pkt(4'b1111);
        run_cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [NT-1:0] tm;
            tm = 4'($urandom);
            if (($urandom % 8) == 0) tm = '0;
            make_pkt(tm);
            run_cycle(($urandom % 4) != 0, ($urandom % 4) != 0);
        end
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
